inst_issue_buffer: RTL and testbench
====================================

Name: inst_issue_buffer

Overview:
- Circular instruction queue between fetch and the dual-issue decode/issue stage.
- Accepts up to two fetched instructions per cycle and presents the two oldest entries to issue.
- Reports 0/1/2 availability to issue and retires 0/1/2 entries per cycle according to the issue mode returned by issue.
- Flushed wholesale on a branch redirect.

Parameters:
- DEPTH, 16, number of entries; power of two, >= 4.
- WIDTH, 131, bits per instruction bus entry (pc, inst, exception/meta fields).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- flush_i  input  1  branch redirect; discards all entries.
- fetch_valid_i  input  2  bit0 = fetch_inst1_i valid, bit1 = fetch_inst2_i valid.
- fetch_inst1_i  input  WIDTH  older fetched instruction.
- fetch_inst2_i  input  WIDTH  younger fetched instruction.
- fetch_allowin_o  output  1  buffer can accept two entries this cycle.
- issue_mode_i  input  2  0 = NoIssue, 1 = SingleIssue, 2 = DoubleIssue, 3 = treated as NoIssue.
- instbuffer_count_o  output  2  0 = HaveNoInst, 1 = HaveOneInst, 2 = HaveTwoInst (saturated).
- inst1_bus_o  output  WIDTH  oldest entry.
- inst2_bus_o  output  WIDTH  second-oldest entry.
- occupancy_o  output  $clog2(DEPTH)+1  exact entry count.

Behaviour:
- State: storage array, head/tail pointers ($clog2(DEPTH) bits, wrap modulo DEPTH), count (0..DEPTH). All state is registered.
- Reset (rst=1 at posedge): head = tail = count = 0. Storage contents are don't-care. While rst is high, fetch_allowin_o = 0. All other outputs follow count = 0: count_o = 0, buses = 0, occupancy_o = 0.
- Priority at each posedge: rst > flush_i > normal update.
- flush_i = 1: head = tail = count = 0. The same-cycle push and pop are discarded.
- Pop amount: pop = min(mode_pops, count), where mode_pops is 0/1/2 for modes 0/1/2 and 0 for mode 3. head += pop.
- fetch_allowin_o = (DEPTH - count) >= 2, computed from registered count only. It takes no credit for a same-cycle pop.
- Push amount: accepted only when fetch_allowin_o = 1.
  - valid 2'b11: write inst1 at tail, inst2 at tail+1; push = 2.
  - valid 2'b01: write inst1 at tail; push = 1.
  - valid 2'b10: write inst2 at tail; push = 1.
  - valid 2'b00: push = 0.
  - tail += push.
  - When fetch_allowin_o = 0, valid is ignored and nothing is written.
- count_next = count - pop + push. Simultaneous push and pop are legal in the same cycle. The count never exceeds DEPTH.
- Outputs are combinational from registered state; zero added latency.
  - inst1_bus_o = mem[head] when count >= 1, else 0.
  - inst2_bus_o = mem[head+1 mod DEPTH] when count >= 2, else 0.
  - instbuffer_count_o = min(count, 2). occupancy_o = count.
- Push-to-visible latency is 1 cycle: an entry written at edge N appears on the outputs after edge N.
- Wrap-around: entries spanning index DEPTH-1 -> 0 must present in order on inst1/inst2.
- Order preserved: FIFO by fetch order, inst1 before inst2 within a pair.

Optional Feature:
- Macro: INST_BUFFER_PERF_EN.
- Defined: adds outputs perf_empty_cycles_o[31:0] and perf_full_cycles_o[31:0].
  - perf_empty_cycles_o counts cycles with count == 0 and no flush.
  - perf_full_cycles_o counts cycles with fetch_allowin_o == 0 and rst == 0.
  - Both are cleared by rst only (not by flush) and wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle: rst 1 cycle -> count_o = 0, occupancy_o = 0, buses = 0, fetch_allowin_o = 1 the cycle after rst drops.
- Push pair A,B with valid = 2'b11, issue_mode = 0 -> next cycle count_o = 2, inst1 = A, inst2 = B. Then mode = 1 -> inst1 = B, count_o = 1. Then mode = 2 -> pop clamped to 1, count_o = 0.
- Fill with DEPTH = 16 using 8 pairs, no pops -> occupancy_o = 16, fetch_allowin_o = 0. A 9th valid pair is dropped. One mode = 2 pop -> occupancy 14, allowin = 1 next cycle.
- Wrap: push and pop at matched rates for 40 cycles with sequential tags -> tags emerge in strict order across the index 15 -> 0 boundary.
- Flush with simultaneous push of 2 and mode = 2 while occupancy = 6 -> next cycle occupancy_o = 0, buses = 0, pushed entries absent.
- valid = 2'b10 with inst2 = X into an empty buffer -> inst1_bus_o = X, count_o = 1. With the macro defined: 3 empty idle cycles -> perf_empty_cycles_o = 3.

Source files
------------

// File: rtl/inst_issue_buffer.sv
// ---------------------------------------------------------------------------
// inst_issue_buffer
//
// Circular instruction queue sitting between fetch and the dual-issue
// decode/issue stage. Fetch may deliver up to two instructions per cycle;
// the two oldest entries are always presented to issue, which hands back an
// issue mode telling the buffer how many of them (0/1/2) were consumed.
// A branch redirect (flush_i) discards everything in the queue.
//
// Parameters:
//   DEPTH  number of entries (power of two, >= 4)
//   WIDTH  bits per instruction bus entry
//
// Ports:
//   clk                 clock, rising edge
//   rst                 synchronous reset, active-high
//   flush_i             branch redirect, empties the buffer
//   fetch_valid_i[1:0]  bit0 = fetch_inst1_i valid, bit1 = fetch_inst2_i valid
//   fetch_inst1_i       older fetched instruction
//   fetch_inst2_i       younger fetched instruction
//   fetch_allowin_o     room for two entries this cycle
//   issue_mode_i[1:0]   0 none, 1 single, 2 double, 3 none
//   instbuffer_count_o  entries available to issue, saturated at 2
//   inst1_bus_o         oldest entry (0 when empty)
//   inst2_bus_o         second-oldest entry (0 when fewer than two)
//   occupancy_o         exact entry count
//
// Optional feature (macro INST_BUFFER_PERF_EN):
//   perf_empty_cycles_o  cycles spent empty without a flush
//   perf_full_cycles_o   cycles in which fetch was refused
//   Both are cleared only by rst and wrap at 2^32.
// ---------------------------------------------------------------------------
module inst_issue_buffer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 131
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic [1:0]             fetch_valid_i,
  input  logic [WIDTH-1:0]       fetch_inst1_i,
  input  logic [WIDTH-1:0]       fetch_inst2_i,
  output logic                   fetch_allowin_o,
  input  logic [1:0]             issue_mode_i,
  output logic [1:0]             instbuffer_count_o,
  output logic [WIDTH-1:0]       inst1_bus_o,
  output logic [WIDTH-1:0]       inst2_bus_o,
`ifdef INST_BUFFER_PERF_EN
  output logic [31:0]            perf_empty_cycles_o,
  output logic [31:0]            perf_full_cycles_o,
`endif
  output logic [$clog2(DEPTH):0] occupancy_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Largest count that still leaves room for a full pair.
  localparam logic [CNT_W-1:0] ALLOW_MAX = CNT_W'(DEPTH - 2);

  // Storage and queue bookkeeping.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [PTR_W-1:0] head_nxt1;
  logic [PTR_W-1:0] tail_nxt1;
  logic             space_ok;
  logic [1:0]       mode_pops;
  logic [1:0]       pop_amt;
  logic [1:0]       push_amt;
  logic             wr0_en;
  logic             wr1_en;
  logic [WIDTH-1:0] wr0_data;
  logic [CNT_W-1:0] vis_count;

  // Neighbour pointers and the "room for a pair" test. Pointers are exactly
  // PTR_W bits wide, so the +1 wraps modulo DEPTH on its own. The space test
  // looks only at the registered count: a pop happening this same cycle does
  // not earn fetch any extra credit.
  always_comb begin
    head_nxt1 = head_q + PTR_W'(1);
    tail_nxt1 = tail_q + PTR_W'(1);
    space_ok  = (count_q <= ALLOW_MAX);
  end

  // Decode the issue mode into a requested pop count, then clamp it to what
  // is actually held so issue can never retire entries that do not exist.
  always_comb begin
    case (issue_mode_i)
      2'd1:    mode_pops = 2'd1;
      2'd2:    mode_pops = 2'd2;
      default: mode_pops = 2'd0;
    endcase

    if (count_q >= CNT_W'(2)) begin
      pop_amt = mode_pops;
    end else if (count_q == CNT_W'(1)) begin
      pop_amt = (mode_pops != 2'd0) ? 2'd1 : 2'd0;
    end else begin
      pop_amt = 2'd0;
    end
  end

  // Decode the fetch valid bits into write enables. A lone younger
  // instruction (valid 2'b10) still lands at the tail slot so the queue
  // stays dense. Writes are suppressed while reset or flush is active so
  // discarded instructions never touch storage.
  always_comb begin
    wr0_en   = 1'b0;
    wr1_en   = 1'b0;
    wr0_data = fetch_inst1_i;
    push_amt = 2'd0;
    if (space_ok && !flush_i && !rst) begin
      case (fetch_valid_i)
        2'b11: begin
          wr0_en   = 1'b1;
          wr1_en   = 1'b1;
          push_amt = 2'd2;
        end
        2'b01: begin
          wr0_en   = 1'b1;
          push_amt = 2'd1;
        end
        2'b10: begin
          wr0_en   = 1'b1;
          wr0_data = fetch_inst2_i;
          push_amt = 2'd1;
        end
        default: begin
          wr0_en   = 1'b0;
        end
      endcase
    end
  end

  // Next-state pointers and count; push and pop in the same cycle combine.
  always_comb begin
    head_d  = head_q + PTR_W'(pop_amt);
    tail_d  = tail_q + PTR_W'(push_amt);
    count_d = count_q - CNT_W'(pop_amt) + CNT_W'(push_amt);
  end

  // Bookkeeping registers. Reset beats flush beats the normal update; a
  // flush throws away any same-cycle push and pop along with the contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage. Contents are don't-care after reset because the outputs
  // are masked by the count, so no reset is applied here.
  always_ff @(posedge clk) begin
    if (wr0_en) begin
      mem_q[tail_q] <= wr0_data;
    end
    if (wr1_en) begin
      mem_q[tail_nxt1] <= fetch_inst2_i;
    end
  end

  // Outputs come straight from registered state. While rst is asserted the
  // buffer presents itself as empty and refuses fetch.
  always_comb begin
    vis_count          = rst ? '0 : count_q;
    fetch_allowin_o    = !rst && space_ok;
    occupancy_o        = vis_count;
    instbuffer_count_o = (vis_count >= CNT_W'(2)) ? 2'd2 : vis_count[1:0];
    inst1_bus_o        = (vis_count != '0) ? mem_q[head_q] : '0;
    inst2_bus_o        = (vis_count >= CNT_W'(2)) ? mem_q[head_nxt1] : '0;
  end

`ifdef INST_BUFFER_PERF_EN
  logic [31:0] perf_empty_q;
  logic [31:0] perf_full_q;

  // Performance counters. Only reset clears them; flushes are part of normal
  // operation and must not hide the history. A cycle that is empty only
  // because of a flush-in-progress is not counted as idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_empty_q <= '0;
      perf_full_q  <= '0;
    end else begin
      if ((count_q == '0) && !flush_i) begin
        perf_empty_q <= perf_empty_q + 32'd1;
      end
      if (!space_ok) begin
        perf_full_q <= perf_full_q + 32'd1;
      end
    end
  end

  assign perf_empty_cycles_o = perf_empty_q;
  assign perf_full_cycles_o  = perf_full_q;
`endif

endmodule

// File: tb/tb_inst_issue_buffer.sv
// ---------------------------------------------------------------------------
// tb_inst_issue_buffer
//
// Drives directed scenarios followed by randomized traffic into
// inst_issue_buffer and compares every output, every cycle, against a
// queue-based reference model of the instruction buffer.
// ---------------------------------------------------------------------------
module tb_inst_issue_buffer;

  localparam int DEPTH = 16;
  localparam int WIDTH = 131;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush_i;
  logic [1:0]       fetch_valid_i;
  logic [WIDTH-1:0] fetch_inst1_i;
  logic [WIDTH-1:0] fetch_inst2_i;
  logic             fetch_allowin_o;
  logic [1:0]       issue_mode_i;
  logic [1:0]       instbuffer_count_o;
  logic [WIDTH-1:0] inst1_bus_o;
  logic [WIDTH-1:0] inst2_bus_o;
  logic [CW-1:0]    occupancy_o;
`ifdef INST_BUFFER_PERF_EN
  logic [31:0]      perf_empty_cycles_o;
  logic [31:0]      perf_full_cycles_o;
  logic [31:0]      expEmpty;
  logic [31:0]      expFull;
`endif

  logic [WIDTH-1:0] modelQ[$];
  int checks = 0;
  int errors = 0;
  int tagCtr = 1;

  always #5 clk = ~clk;

  inst_issue_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .flush_i            (flush_i),
    .fetch_valid_i      (fetch_valid_i),
    .fetch_inst1_i      (fetch_inst1_i),
    .fetch_inst2_i      (fetch_inst2_i),
    .fetch_allowin_o    (fetch_allowin_o),
    .issue_mode_i       (issue_mode_i),
    .instbuffer_count_o (instbuffer_count_o),
    .inst1_bus_o        (inst1_bus_o),
    .inst2_bus_o        (inst2_bus_o),
`ifdef INST_BUFFER_PERF_EN
    .perf_empty_cycles_o(perf_empty_cycles_o),
    .perf_full_cycles_o (perf_full_cycles_o),
`endif
    .occupancy_o        (occupancy_o)
  );

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs,
                             input logic [WIDTH-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Unique, recognisable instruction word carrying a tag in both ends.
  function automatic logic [WIDTH-1:0] mkInst(input int t);
    logic [WIDTH-1:0] x;
    x = WIDTH'(t);
    x[WIDTH-1 -: 16] = 16'(t) ^ 16'hA5A5;
    return x;
  endfunction

  function automatic logic [WIDTH-1:0] randInst();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[WIDTH-1:0];
  endfunction

  // One clock cycle: drive inputs, compare outputs with the model, then let
  // the edge happen and advance the model by the same inputs.
  task automatic applyStimulus(input logic r, input logic f, input logic [1:0] v,
                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [1:0] m);
    int sz;
    int pops;
    bit allow;
    rst           = r;
    flush_i       = f;
    fetch_valid_i = v;
    fetch_inst1_i = a;
    fetch_inst2_i = b;
    issue_mode_i  = m;
    #1;
    sz    = r ? 0 : modelQ.size();
    allow = !r && ((DEPTH - modelQ.size()) >= 2);
    checkOutput("allowin", WIDTH'(fetch_allowin_o), WIDTH'(allow));
    checkOutput("count", WIDTH'(instbuffer_count_o), WIDTH'((sz > 2) ? 2 : sz));
    checkOutput("occupancy", WIDTH'(occupancy_o), WIDTH'(sz));
    checkOutput("inst1", inst1_bus_o, (sz >= 1) ? modelQ[0] : '0);
    checkOutput("inst2", inst2_bus_o, (sz >= 2) ? modelQ[1] : '0);
`ifdef INST_BUFFER_PERF_EN
    if (!r) begin
      checkOutput("perfEmpty", WIDTH'(perf_empty_cycles_o), WIDTH'(expEmpty));
      checkOutput("perfFull", WIDTH'(perf_full_cycles_o), WIDTH'(expFull));
    end
`endif
    @(posedge clk);
`ifdef INST_BUFFER_PERF_EN
    if (r) begin
      expEmpty = '0;
      expFull  = '0;
    end else begin
      if (modelQ.size() == 0 && !f) expEmpty++;
      if ((DEPTH - modelQ.size()) < 2) expFull++;
    end
`endif
    if (r || f) begin
      modelQ.delete();
    end else begin
      pops = (m == 2'd1) ? 1 : (m == 2'd2) ? 2 : 0;
      if (pops > modelQ.size()) pops = modelQ.size();
      repeat (pops) void'(modelQ.pop_front());
      if (allow) begin
        if (v[0]) modelQ.push_back(a);
        if (v[1]) modelQ.push_back(b);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [1:0] m);
    applyStimulus(1'b0, 1'b0, 2'b00, '0, '0, m);
  endtask

  task automatic pushPair(input logic [1:0] m);
    applyStimulus(1'b0, 1'b0, 2'b11, mkInst(tagCtr), mkInst(tagCtr + 1), m);
    tagCtr += 2;
  endtask

  logic [WIDTH-1:0] instX;
  bit heavyPush;

  initial begin
    @(negedge clk);
    // Reset, then idle: buffer empty and open to fetch.
    applyStimulus(1'b1, 1'b0, 2'b11, mkInst(900), mkInst(901), 2'd0);
    checkOutput("rstOcc", WIDTH'(occupancy_o), '0);
    idle(2'd0);

    // Pair A,B then single and (clamped) double issue.
    pushPair(2'd0);
    checkOutput("pairInst1", inst1_bus_o, mkInst(tagCtr - 2));
    checkOutput("pairInst2", inst2_bus_o, mkInst(tagCtr - 1));
    idle(2'd1);
    checkOutput("singleInst1", inst1_bus_o, mkInst(tagCtr - 1));
    idle(2'd2);
    checkOutput("clampOcc", WIDTH'(occupancy_o), '0);
    idle(2'd0);

    // Fill to DEPTH, ninth pair dropped, one double pop reopens fetch.
    repeat (DEPTH / 2) pushPair(2'd0);
    checkOutput("fullAllowin", WIDTH'(fetch_allowin_o), '0);
    pushPair(2'd0);
    checkOutput("ninthDropped", WIDTH'(occupancy_o), WIDTH'(DEPTH));
    idle(2'd2);
    checkOutput("afterPopOcc", WIDTH'(occupancy_o), WIDTH'(DEPTH - 2));
    checkOutput("afterPopAllowin", WIDTH'(fetch_allowin_o), WIDTH'(1));
    repeat (DEPTH / 2) idle(2'd2);

    // Wrap: matched single push/pop across the DEPTH-1 -> 0 boundary.
    pushPair(2'd0);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 1'b0, 2'b01, mkInst(tagCtr), '0, 2'd1);
      tagCtr++;
    end
    repeat (2) idle(2'd2);

    // Flush with occupancy 6 and simultaneous push/pop.
    repeat (3) pushPair(2'd0);
    checkOutput("preFlushOcc", WIDTH'(occupancy_o), WIDTH'(6));
    applyStimulus(1'b0, 1'b1, 2'b11, mkInst(777), mkInst(778), 2'd2);
    checkOutput("flushOcc", WIDTH'(occupancy_o), '0);
    checkOutput("flushInst1", inst1_bus_o, '0);

    // Lone younger instruction into an empty buffer.
    instX = mkInst(555);
    applyStimulus(1'b0, 1'b0, 2'b10, mkInst(554), instX, 2'd0);
    checkOutput("loneInst1", inst1_bus_o, instX);
    checkOutput("loneCount", WIDTH'(instbuffer_count_o), WIDTH'(1));
    idle(2'd1);
    repeat (3) idle(2'd0);

    // Randomized traffic in alternating fill/drain phases.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] m;
      heavyPush = ((i / 150) % 2) == 0;
      m = (heavyPush && $urandom_range(0, 3) != 0) ? 2'd0 : 2'($urandom_range(0, 3));
      applyStimulus(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 47) == 0),
                    2'($urandom_range(0, 3)), randInst(), randInst(), m);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
